lnrv_ilm_arb: RTL and testbench
===============================

Name: lnrv_ilm_arb

Overview:
Two-master arbiter that shares the single-port ILM SRAM between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write) inside lnrv_cpu. It accepts valid/ready commands from both masters and drives one SRAM access per cycle. It routes the 1-cycle-latency SRAM read data back to the owning master through a per-master response buffer. LSU has fixed priority, and a starvation counter guarantees IFU forward progress.

Parameters:
P_ADDR_WIDTH, 16, ILM word-address width (ilm_addr width)
P_DATA_WIDTH, 32, data width; wem width = P_DATA_WIDTH/8
P_STARVE_LIMIT, 4, consecutive lost IFU request cycles before IFU is forced to win; range 1..15

Ports:
clk  in  1  core clock, sole clock domain
reset_n  in  1  asynchronous active-low reset
ifu_cmd_valid  in  1  IFU read request
ifu_cmd_ready  out  1  IFU request accepted this cycle
ifu_cmd_addr  in  P_ADDR_WIDTH  IFU word address
ifu_rsp_valid  out  1  IFU read data valid
ifu_rsp_ready  in  1  IFU accepts response
ifu_rsp_rdata  out  P_DATA_WIDTH  IFU read data
lsu_cmd_valid  in  1  LSU request
lsu_cmd_ready  out  1  LSU request accepted
lsu_cmd_we  in  1  1 = write, 0 = read
lsu_cmd_wem  in  P_DATA_WIDTH/8  byte write mask
lsu_cmd_addr  in  P_ADDR_WIDTH  LSU word address
lsu_cmd_wdata  in  P_DATA_WIDTH  LSU write data
lsu_rsp_valid  out  1  LSU response (read data or write ack)
lsu_rsp_ready  in  1  LSU accepts response
lsu_rsp_rdata  out  P_DATA_WIDTH  LSU read data; 0 for write acks
ilm_cs  out  1  SRAM chip select
ilm_we  out  1  SRAM write enable
ilm_wem  out  P_DATA_WIDTH/8  SRAM byte mask
ilm_addr  out  P_ADDR_WIDTH  SRAM word address
ilm_wdata  out  P_DATA_WIDTH  SRAM write data
ilm_rdata  in  P_DATA_WIDTH  SRAM read data, valid the cycle after cs

Behaviour:
- Single clock clk; reset is asynchronous and active-low on reset_n. All state clears immediately on reset_n low.
- Reset values: all *_rsp_valid=0, *_cmd_ready=0, ilm_cs=0, ilm_we=0, ilm_wem=0, starvation counter=0, all slots EMPTY.
- Per-master response slot, states:
  - EMPTY
  - PEND: access issued last cycle; data comes live from ilm_rdata
  - BUF: data held in a register
- Slot transitions:
  - EMPTY -> PEND on grant.
  - PEND: rsp_valid=1 and rsp_rdata=ilm_rdata (0 if write).
    - rsp_ready=1: go to EMPTY, or stay PEND if re-granted the same cycle.
    - rsp_ready=0: capture ilm_rdata into the buffer and go to BUF.
  - BUF: rsp_valid=1 and rsp_rdata=buffer.
    - rsp_ready=1: go to EMPTY, or to PEND if re-granted the same cycle.
- Eligibility: master m is eligible when cmd_valid=1 and (slot EMPTY, or slot PEND/BUF with rsp_ready=1 this cycle). At most one outstanding-plus-buffered response per master.
- Arbitration (combinational, same cycle):
  - LSU wins when both are eligible.
  - Exception: the starvation counter has reached P_STARVE_LIMIT, in which case IFU wins.
  - A grant raises that master's cmd_ready, drives ilm_cs=1, and drives addr/we/wem/wdata from the winner.
  - IFU grants always drive ilm_we=0 and ilm_wem=0.
  - Idle cycles drive ilm_cs=0; ilm_we and ilm_wem are also forced to 0.
- Starvation counter (saturating):
  - Increments when ifu_cmd_valid=1, IFU is eligible, and IFU is not granted.
  - Clears when IFU is granted or ifu_cmd_valid=0.
- Latency: command accepted in cycle N gives rsp_valid in cycle N+1. Sustained throughput is 1 access/cycle total with rsp_ready held high.
- LSU writes: the SRAM is written on the grant edge, and the write ack appears at N+1 with rdata=0.
- Simultaneous events: each master's rsp handshake and new grant in the same cycle is legal and loses no data. Only one SRAM access ever occurs per cycle.
- cmd fields must stay stable while cmd_valid=1 and cmd_ready=0 (master obligation). The arbiter never drops a pending command.
- Reset mid-operation: outstanding responses are discarded and no rsp_valid follows reset release.

Test Plan:
- IFU-only burst: 4 reads at addrs 0..3, rsp_ready=1, SRAM word i = 0x1000+i -> ifu_rsp_valid in cycles N+1..N+4, data 0x1000..0x1003, ilm_cs high 4 consecutive cycles.
- Contention: both valid continuously, P_STARVE_LIMIT=4 -> grant pattern LSU×4, IFU×1, repeating; counter returns to 0 after each IFU grant.
- Backpressure: IFU read of 0xCAFEF00D with ifu_rsp_ready=0 for 3 cycles -> ifu_rsp_valid held with stable 0xCAFEF00D; ifu_cmd_ready=0 for a second IFU request until ready rises; ready and the new grant occur in the same cycle.
- LSU byte write: addr 0x10, wem=4'b0100, wdata=0x00AB0000 over word 0x11223344 -> ilm_we=1, lsu_rsp_valid next cycle with rdata=0; subsequent LSU read returns 0x11AB3344.
- Reset mid-operation: drop reset_n while an IFU slot is in BUF -> all outputs go to 0 asynchronously; after release, no spurious rsp_valid and the next IFU read works normally.

Source files
------------

// File: rtl/lnrv_ilm_arb_if.sv
// lnrv_ilm_arb_if: bundle of the IFU and LSU command/response channels and the
// ILM SRAM port that lnrv_ilm_arb arbitrates.
//   slave  modport : arbiter view (takes commands, returns responses, drives SRAM)
//   master modport : environment view (IFU, LSU and SRAM side)
//   ifu_cmd_*/ifu_rsp_* : IFU read-only valid/ready channels
//   lsu_cmd_*/lsu_rsp_* : LSU read/write valid/ready channels
//   ilm_*               : single-port SRAM, 1-cycle read latency
interface lnrv_ilm_arb_if #(
    parameter int P_ADDR_WIDTH = 16,
    parameter int P_DATA_WIDTH = 32
);
    localparam int P_WEM_WIDTH = P_DATA_WIDTH / 8;

    logic                    ifu_cmd_valid;
    logic                    ifu_cmd_ready;
    logic [P_ADDR_WIDTH-1:0] ifu_cmd_addr;
    logic                    ifu_rsp_valid;
    logic                    ifu_rsp_ready;
    logic [P_DATA_WIDTH-1:0] ifu_rsp_rdata;

    logic                    lsu_cmd_valid;
    logic                    lsu_cmd_ready;
    logic                    lsu_cmd_we;
    logic [P_WEM_WIDTH-1:0]  lsu_cmd_wem;
    logic [P_ADDR_WIDTH-1:0] lsu_cmd_addr;
    logic [P_DATA_WIDTH-1:0] lsu_cmd_wdata;
    logic                    lsu_rsp_valid;
    logic                    lsu_rsp_ready;
    logic [P_DATA_WIDTH-1:0] lsu_rsp_rdata;

    logic                    ilm_cs;
    logic                    ilm_we;
    logic [P_WEM_WIDTH-1:0]  ilm_wem;
    logic [P_ADDR_WIDTH-1:0] ilm_addr;
    logic [P_DATA_WIDTH-1:0] ilm_wdata;
    logic [P_DATA_WIDTH-1:0] ilm_rdata;

    modport slave (
        input  ifu_cmd_valid, ifu_cmd_addr, ifu_rsp_ready,
        output ifu_cmd_ready, ifu_rsp_valid, ifu_rsp_rdata,
        input  lsu_cmd_valid, lsu_cmd_we, lsu_cmd_wem, lsu_cmd_addr, lsu_cmd_wdata, lsu_rsp_ready,
        output lsu_cmd_ready, lsu_rsp_valid, lsu_rsp_rdata,
        output ilm_cs, ilm_we, ilm_wem, ilm_addr, ilm_wdata,
        input  ilm_rdata
    );

    modport master (
        output ifu_cmd_valid, ifu_cmd_addr, ifu_rsp_ready,
        input  ifu_cmd_ready, ifu_rsp_valid, ifu_rsp_rdata,
        output lsu_cmd_valid, lsu_cmd_we, lsu_cmd_wem, lsu_cmd_addr, lsu_cmd_wdata, lsu_rsp_ready,
        input  lsu_cmd_ready, lsu_rsp_valid, lsu_rsp_rdata,
        input  ilm_cs, ilm_we, ilm_wem, ilm_addr, ilm_wdata,
        output ilm_rdata
    );
endinterface

// File: rtl/lnrv_ilm_arb.sv
// lnrv_ilm_arb: shares the single-port ILM SRAM between IFU (reads) and LSU
// (reads/writes). LSU has fixed priority; a saturating starvation counter
// forces an IFU win after P_STARVE_LIMIT lost cycles. Each master owns a
// one-deep response slot so read data survives response backpressure.
//   clk     : core clock
//   reset_n : asynchronous active-low reset
//   bus     : lnrv_ilm_arb_if.slave (IFU/LSU channels + SRAM port)

// Per-master response slot. EMPTY -> PEND on grant; PEND forwards ilm_rdata
// live, or parks it in buf_q (BUF) when the master is not ready.
module lnrv_ilm_arb_slot #(
    parameter int P_DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    grant,
    input  logic                    grant_we,
    input  logic                    rsp_ready,
    input  logic [P_DATA_WIDTH-1:0] ilm_rdata,
    output logic                    rsp_valid,
    output logic [P_DATA_WIDTH-1:0] rsp_rdata
);
    typedef enum logic [1:0] {S_EMPTY, S_PEND, S_BUF} state_e;

    state_e                  state_q, state_d;
    logic                    wr_q;    // outstanding access is a write: return 0
    logic [P_DATA_WIDTH-1:0] buf_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_EMPTY;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q  <= 1'b0;
            buf_q <= '0;
        end else begin
            if (grant) wr_q <= grant_we;
            if (state_q == S_PEND && !rsp_ready) buf_q <= wr_q ? '0 : ilm_rdata;
        end
    end

    // A grant while PEND/BUF only happens when rsp_ready=1 (eligibility rule),
    // so the handshake frees the slot in the same cycle it is refilled.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY: if (grant) state_d = S_PEND;
            S_PEND:  state_d = rsp_ready ? (grant ? S_PEND : S_EMPTY) : S_BUF;
            S_BUF:   if (rsp_ready) state_d = grant ? S_PEND : S_EMPTY;
            default: state_d = S_EMPTY;
        endcase
    end

    always_comb begin
        rsp_valid = (state_q != S_EMPTY);
        rsp_rdata = '0;
        if (state_q == S_BUF)               rsp_rdata = buf_q;
        else if (state_q == S_PEND && !wr_q) rsp_rdata = ilm_rdata;
    end
endmodule

module lnrv_ilm_arb #(
    parameter int P_ADDR_WIDTH   = 16,
    parameter int P_DATA_WIDTH   = 32,
    parameter int P_STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    lnrv_ilm_arb_if.slave bus
);
    localparam int NUM_M = 2;
    localparam int M_IFU = 0;
    localparam int M_LSU = 1;

    logic [NUM_M-1:0]                   cmd_valid, rsp_ready, rsp_valid;
    logic [NUM_M-1:0]                   elig, gnt, gnt_we;
    logic [NUM_M-1:0][P_DATA_WIDTH-1:0] rsp_rdata;
    logic [3:0]                         starve_q;
    logic                               starve_hit;

    assign cmd_valid = {bus.lsu_cmd_valid, bus.ifu_cmd_valid};
    assign rsp_ready = {bus.lsu_rsp_ready, bus.ifu_rsp_ready};
    assign gnt_we    = {bus.lsu_cmd_we, 1'b0};

    // Eligible when the slot is free now or frees this cycle via handshake.
    assign elig       = cmd_valid & (~rsp_valid | rsp_ready);
    assign starve_hit = (starve_q >= 4'(P_STARVE_LIMIT));

    // Grants are gated by reset_n so cmd_ready/ilm_cs read 0 while in reset
    // even if masters keep cmd_valid high.
    always_comb begin
        gnt        = '0;
        gnt[M_IFU] = reset_n & elig[M_IFU] & (~elig[M_LSU] | starve_hit);
        gnt[M_LSU] = reset_n & elig[M_LSU] & ~gnt[M_IFU];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                             starve_q <= '0;
        else if (!cmd_valid[M_IFU] || gnt[M_IFU]) starve_q <= '0;
        else if (elig[M_IFU] && !starve_hit)      starve_q <= starve_q + 4'd1;
    end

    for (genvar m = 0; m < NUM_M; m++) begin : g_slot
        lnrv_ilm_arb_slot #(.P_DATA_WIDTH(P_DATA_WIDTH)) u_slot (
            .clk       (clk),
            .reset_n   (reset_n),
            .grant     (gnt[m]),
            .grant_we  (gnt_we[m]),
            .rsp_ready (rsp_ready[m]),
            .ilm_rdata (bus.ilm_rdata),
            .rsp_valid (rsp_valid[m]),
            .rsp_rdata (rsp_rdata[m])
        );
    end

    assign bus.ifu_cmd_ready = gnt[M_IFU];
    assign bus.lsu_cmd_ready = gnt[M_LSU];
    assign bus.ifu_rsp_valid = rsp_valid[M_IFU];
    assign bus.lsu_rsp_valid = rsp_valid[M_LSU];
    assign bus.ifu_rsp_rdata = rsp_rdata[M_IFU];
    assign bus.lsu_rsp_rdata = rsp_rdata[M_LSU];

    // SRAM port: everything zero on idle cycles; IFU never writes.
    always_comb begin
        bus.ilm_cs    = 1'b0;
        bus.ilm_we    = 1'b0;
        bus.ilm_wem   = '0;
        bus.ilm_addr  = '0;
        bus.ilm_wdata = '0;
        if (gnt[M_LSU]) begin
            bus.ilm_cs    = 1'b1;
            bus.ilm_we    = bus.lsu_cmd_we;
            bus.ilm_wem   = bus.lsu_cmd_we ? bus.lsu_cmd_wem : '0;
            bus.ilm_addr  = bus.lsu_cmd_addr;
            bus.ilm_wdata = bus.lsu_cmd_wdata;
        end else if (gnt[M_IFU]) begin
            bus.ilm_cs   = 1'b1;
            bus.ilm_addr = bus.ifu_cmd_addr;
        end
    end
endmodule

// File: tb/tb_lnrv_ilm_arb.sv
// tb_lnrv_ilm_arb: self-checking bench for lnrv_ilm_arb. A behavioural SRAM
// answers the DUT; a reference memory plus per-master queues predict every
// response at grant time and compare at the response handshake.
module tb_lnrv_ilm_arb;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    lnrv_ilm_arb_if #(.P_ADDR_WIDTH(AW), .P_DATA_WIDTH(DW)) bus ();

    lnrv_ilm_arb #(.P_ADDR_WIDTH(AW), .P_DATA_WIDTH(DW), .P_STARVE_LIMIT(LIMIT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Behavioural SRAM (driven only by DUT outputs and the preload port).
    logic [DW-1:0] sram [0:255];
    logic          pl_we = 1'b0;
    logic [7:0]    pl_addr = '0;
    logic [DW-1:0] pl_data = '0;

    always @(posedge clk) begin
        if (pl_we) sram[pl_addr] <= pl_data;
        else if (bus.ilm_cs) begin
            if (bus.ilm_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus.ilm_wem[b]) sram[bus.ilm_addr[7:0]][8*b +: 8] <= bus.ilm_wdata[8*b +: 8];
            end else begin
                bus.ilm_rdata <= sram[bus.ilm_addr[7:0]];
            end
        end
    end

    logic [DW-1:0] ref_mem [0:255];
    logic [DW-1:0] q_ifu[$];
    logic [DW-1:0] q_lsu[$];
    logic [DW-1:0] exp_d;
    int errs = 0;
    int checks = 0;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ifu_cmd_valid = 1'b0; bus.ifu_cmd_addr = '0; bus.ifu_rsp_ready = 1'b1;
        bus.lsu_cmd_valid = 1'b0; bus.lsu_cmd_we = 1'b0; bus.lsu_cmd_wem = '0;
        bus.lsu_cmd_addr = '0; bus.lsu_cmd_wdata = '0; bus.lsu_rsp_ready = 1'b1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [DW-1:0] d);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        ref_mem[a] = d;
        cyc();
        pl_we = 1'b0;
    endtask

    // Scoreboard step at mid-cycle: pop/compare handshaken responses, then
    // push predictions for this cycle's grants.
    task automatic sb_tick();
        if (bus.ifu_rsp_valid && bus.ifu_rsp_ready) begin
            checks++;
            if (q_ifu.size() == 0) begin
                errs++; $display("FAIL ifu_rsp_spurious: got rdata %h, none expected", bus.ifu_rsp_rdata);
            end else begin
                exp_d = q_ifu.pop_front();
                if (bus.ifu_rsp_rdata !== exp_d) begin
                    errs++; $display("FAIL ifu_rsp_data: got %h expected %h", bus.ifu_rsp_rdata, exp_d);
                end
            end
        end
        if (bus.lsu_rsp_valid && bus.lsu_rsp_ready) begin
            checks++;
            if (q_lsu.size() == 0) begin
                errs++; $display("FAIL lsu_rsp_spurious: got rdata %h, none expected", bus.lsu_rsp_rdata);
            end else begin
                exp_d = q_lsu.pop_front();
                if (bus.lsu_rsp_rdata !== exp_d) begin
                    errs++; $display("FAIL lsu_rsp_data: got %h expected %h", bus.lsu_rsp_rdata, exp_d);
                end
            end
        end
        if (bus.ifu_cmd_ready === 1'b1 && bus.lsu_cmd_ready === 1'b1) begin
            checks++; errs++;
            $display("FAIL double_grant: ifu_cmd_ready=1 lsu_cmd_ready=1, expected at most one");
        end
        if (bus.ifu_cmd_valid && bus.ifu_cmd_ready) begin
            checks++;
            if (bus.ilm_cs !== 1'b1 || bus.ilm_we !== 1'b0 || bus.ilm_wem !== 4'b0 || bus.ilm_addr !== bus.ifu_cmd_addr) begin
                errs++; $display("FAIL ifu_issue: cs=%b we=%b wem=%b addr=%h expected 1 0 0000 %h",
                                 bus.ilm_cs, bus.ilm_we, bus.ilm_wem, bus.ilm_addr, bus.ifu_cmd_addr);
            end
            q_ifu.push_back(ref_mem[bus.ifu_cmd_addr[7:0]]);
        end
        if (bus.lsu_cmd_valid && bus.lsu_cmd_ready) begin
            checks++;
            if (bus.ilm_cs !== 1'b1 || bus.ilm_we !== bus.lsu_cmd_we || bus.ilm_addr !== bus.lsu_cmd_addr ||
                (bus.lsu_cmd_we && (bus.ilm_wem !== bus.lsu_cmd_wem || bus.ilm_wdata !== bus.lsu_cmd_wdata))) begin
                errs++; $display("FAIL lsu_issue: cs=%b we=%b wem=%b addr=%h wdata=%h expected we=%b wem=%b addr=%h wdata=%h",
                                 bus.ilm_cs, bus.ilm_we, bus.ilm_wem, bus.ilm_addr, bus.ilm_wdata,
                                 bus.lsu_cmd_we, bus.lsu_cmd_wem, bus.lsu_cmd_addr, bus.lsu_cmd_wdata);
            end
            if (bus.lsu_cmd_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus.lsu_cmd_wem[b]) ref_mem[bus.lsu_cmd_addr[7:0]][8*b +: 8] = bus.lsu_cmd_wdata[8*b +: 8];
                q_lsu.push_back('0);
            end else begin
                q_lsu.push_back(ref_mem[bus.lsu_cmd_addr[7:0]]);
            end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.ifu_cmd_valid = 1'b1;
        bus.lsu_cmd_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.ifu_cmd_ready !== 1'b0 || bus.lsu_cmd_ready !== 1'b0) begin
            errs++; $display("FAIL reset_cmd_ready: ifu=%b lsu=%b expected 0 0", bus.ifu_cmd_ready, bus.lsu_cmd_ready);
        end
        checks++;
        if (bus.ifu_rsp_valid !== 1'b0 || bus.lsu_rsp_valid !== 1'b0) begin
            errs++; $display("FAIL reset_rsp_valid: ifu=%b lsu=%b expected 0 0", bus.ifu_rsp_valid, bus.lsu_rsp_valid);
        end
        checks++;
        if (bus.ilm_cs !== 1'b0 || bus.ilm_we !== 1'b0 || bus.ilm_wem !== 4'b0) begin
            errs++; $display("FAIL reset_ilm: cs=%b we=%b wem=%b expected 0 0 0000", bus.ilm_cs, bus.ilm_we, bus.ilm_wem);
        end
        cyc();
        idle_inputs();
        for (int a = 0; a < 256; a++) preload(8'(a), 32'h1000 + a);
        preload(8'h10, 32'h11223344);
        preload(8'h20, 32'hCAFEF00D);
        preload(8'h30, 32'h5555AAAA);
        reset_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); sb_tick();
            checks++;
            if (bus.ifu_rsp_valid !== 1'b0 || bus.lsu_rsp_valid !== 1'b0 || bus.ilm_cs !== 1'b0) begin
                errs++; $display("FAIL post_reset_idle: ifu_rsp_valid=%b lsu_rsp_valid=%b cs=%b expected 0 0 0",
                                 bus.ifu_rsp_valid, bus.lsu_rsp_valid, bus.ilm_cs);
            end
            cyc();
        end
    endtask

    task automatic test_ifu_burst();
        for (int i = 0; i <= 4; i++) begin
            bus.ifu_cmd_valid = (i < 4);
            bus.ifu_cmd_addr  = 16'(i);
            @(negedge clk); sb_tick();
            checks++;
            if (bus.ifu_cmd_ready !== (i < 4) || bus.ilm_cs !== (i < 4)) begin
                errs++; $display("FAIL burst_issue[%0d]: cmd_ready=%b cs=%b expected %b", i, bus.ifu_cmd_ready, bus.ilm_cs, (i < 4));
            end
            if (i > 0) begin
                checks++;
                if (bus.ifu_rsp_valid !== 1'b1) begin
                    errs++; $display("FAIL burst_rsp_valid[%0d]: got %b expected 1", i, bus.ifu_rsp_valid);
                end
            end
            cyc();
        end
        @(negedge clk); sb_tick();
        checks++;
        if (bus.ifu_rsp_valid !== 1'b0) begin
            errs++; $display("FAIL burst_rsp_end: ifu_rsp_valid=%b expected 0", bus.ifu_rsp_valid);
        end
        cyc();
    endtask

    task automatic test_contention();
        logic exp_ifu;
        bus.ifu_cmd_valid = 1'b1; bus.ifu_cmd_addr = 16'h0040;
        bus.lsu_cmd_valid = 1'b1; bus.lsu_cmd_we = 1'b0; bus.lsu_cmd_addr = 16'h0041;
        for (int k = 0; k < 15; k++) begin
            exp_ifu = ((k % (LIMIT + 1)) == LIMIT);
            @(negedge clk); sb_tick();
            checks++;
            if (bus.ifu_cmd_ready !== exp_ifu || bus.lsu_cmd_ready !== !exp_ifu) begin
                errs++; $display("FAIL contention_grant[%0d]: ifu_ready=%b lsu_ready=%b expected %b %b",
                                 k, bus.ifu_cmd_ready, bus.lsu_cmd_ready, exp_ifu, !exp_ifu);
            end
            cyc();
        end
        idle_inputs();
        @(negedge clk); sb_tick();
        cyc();
    endtask

    task automatic test_backpressure();
        bus.ifu_rsp_ready = 1'b0;
        bus.ifu_cmd_valid = 1'b1; bus.ifu_cmd_addr = 16'h0020;
        @(negedge clk); sb_tick();
        checks++;
        if (bus.ifu_cmd_ready !== 1'b1) begin
            errs++; $display("FAIL bp_first_grant: ifu_cmd_ready=%b expected 1", bus.ifu_cmd_ready);
        end
        cyc();
        bus.ifu_cmd_addr = 16'h0021;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); sb_tick();
            checks++;
            if (bus.ifu_rsp_valid !== 1'b1 || bus.ifu_rsp_rdata !== 32'hCAFEF00D) begin
                errs++; $display("FAIL bp_hold[%0d]: valid=%b rdata=%h expected 1 cafef00d", c, bus.ifu_rsp_valid, bus.ifu_rsp_rdata);
            end
            checks++;
            if (bus.ifu_cmd_ready !== 1'b0 || bus.ilm_cs !== 1'b0) begin
                errs++; $display("FAIL bp_block[%0d]: cmd_ready=%b cs=%b expected 0 0", c, bus.ifu_cmd_ready, bus.ilm_cs);
            end
            cyc();
        end
        bus.ifu_rsp_ready = 1'b1;
        @(negedge clk); sb_tick();
        checks++;
        if (bus.ifu_cmd_ready !== 1'b1) begin
            errs++; $display("FAIL bp_same_cycle_grant: ifu_cmd_ready=%b expected 1", bus.ifu_cmd_ready);
        end
        cyc();
        bus.ifu_cmd_valid = 1'b0;
        @(negedge clk); sb_tick();
        checks++;
        if (bus.ifu_rsp_valid !== 1'b1) begin
            errs++; $display("FAIL bp_second_rsp: ifu_rsp_valid=%b expected 1", bus.ifu_rsp_valid);
        end
        cyc();
        @(negedge clk); sb_tick();
        cyc();
    endtask

    task automatic test_lsu_write();
        bus.lsu_cmd_valid = 1'b1; bus.lsu_cmd_we = 1'b1; bus.lsu_cmd_wem = 4'b0100;
        bus.lsu_cmd_addr = 16'h0010; bus.lsu_cmd_wdata = 32'h00AB0000;
        @(negedge clk); sb_tick();
        checks++;
        if (bus.lsu_cmd_ready !== 1'b1 || bus.ilm_we !== 1'b1 || bus.ilm_wem !== 4'b0100) begin
            errs++; $display("FAIL wr_issue: ready=%b we=%b wem=%b expected 1 1 0100", bus.lsu_cmd_ready, bus.ilm_we, bus.ilm_wem);
        end
        cyc();
        bus.lsu_cmd_we = 1'b0; bus.lsu_cmd_wem = '0; bus.lsu_cmd_wdata = '0;
        @(negedge clk); sb_tick();
        checks++;
        if (bus.lsu_rsp_valid !== 1'b1 || bus.lsu_rsp_rdata !== 32'h0) begin
            errs++; $display("FAIL wr_ack: valid=%b rdata=%h expected 1 00000000", bus.lsu_rsp_valid, bus.lsu_rsp_rdata);
        end
        cyc();
        bus.lsu_cmd_valid = 1'b0;
        @(negedge clk); sb_tick();
        checks++;
        if (bus.lsu_rsp_valid !== 1'b1 || bus.lsu_rsp_rdata !== 32'h11AB3344) begin
            errs++; $display("FAIL wr_readback: valid=%b rdata=%h expected 1 11ab3344", bus.lsu_rsp_valid, bus.lsu_rsp_rdata);
        end
        cyc();
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        bus.ifu_rsp_ready = 1'b0;
        bus.ifu_cmd_valid = 1'b1; bus.ifu_cmd_addr = 16'h0030;
        @(negedge clk); sb_tick();
        cyc();
        bus.ifu_cmd_valid = 1'b0;
        @(negedge clk); sb_tick();
        cyc();
        @(negedge clk); sb_tick();
        checks++;
        if (bus.ifu_rsp_valid !== 1'b1 || bus.ifu_rsp_rdata !== 32'h5555AAAA) begin
            errs++; $display("FAIL rm_buf: valid=%b rdata=%h expected 1 5555aaaa", bus.ifu_rsp_valid, bus.ifu_rsp_rdata);
        end
        #2;
        reset_n = 1'b0;
        bus.lsu_cmd_valid = 1'b1; bus.lsu_cmd_addr = 16'h0050;
        q_ifu.delete();
        q_lsu.delete();
        #1;
        checks++;
        if (bus.ifu_rsp_valid !== 1'b0 || bus.ifu_rsp_rdata !== 32'h0 || bus.lsu_cmd_ready !== 1'b0 ||
            bus.ilm_cs !== 1'b0 || bus.ilm_we !== 1'b0 || bus.ilm_wem !== 4'b0) begin
            errs++; $display("FAIL rm_async_clear: rsp_valid=%b rdata=%h lsu_ready=%b cs=%b we=%b wem=%b expected all 0",
                             bus.ifu_rsp_valid, bus.ifu_rsp_rdata, bus.lsu_cmd_ready, bus.ilm_cs, bus.ilm_we, bus.ilm_wem);
        end
        cyc();
        cyc();
        idle_inputs();
        #2;
        reset_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); sb_tick();
            checks++;
            if (bus.ifu_rsp_valid !== 1'b0 || bus.lsu_rsp_valid !== 1'b0) begin
                errs++; $display("FAIL rm_no_spurious[%0d]: ifu=%b lsu=%b expected 0 0", c, bus.ifu_rsp_valid, bus.lsu_rsp_valid);
            end
            cyc();
        end
        bus.ifu_cmd_valid = 1'b1; bus.ifu_cmd_addr = 16'h0031;
        @(negedge clk); sb_tick();
        checks++;
        if (bus.ifu_cmd_ready !== 1'b1) begin
            errs++; $display("FAIL rm_regrant: ifu_cmd_ready=%b expected 1", bus.ifu_cmd_ready);
        end
        cyc();
        bus.ifu_cmd_valid = 1'b0;
        @(negedge clk); sb_tick();
        checks++;
        if (bus.ifu_rsp_valid !== 1'b1) begin
            errs++; $display("FAIL rm_rsp: ifu_rsp_valid=%b expected 1", bus.ifu_rsp_valid);
        end
        cyc();
    endtask

    initial begin
        test_reset();
        test_ifu_burst();
        test_contention();
        test_backpressure();
        test_lsu_write();
        test_reset_mid();
        checks++;
        if (q_ifu.size() != 0 || q_lsu.size() != 0) begin
            errs++; $display("FAIL sb_drain: ifu pending=%0d lsu pending=%0d expected 0 0", q_ifu.size(), q_lsu.size());
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
